// File: rtl/frame_bit_aligner.sv
// Bit-alignment front end for an 8-bit funnel shifter. It hunts for a periodic
// sync byte across all 8 bit offsets, locks the offset and flags payload bytes.
module frame_bit_aligner #(
  parameter logic [7:0]  SYNC       = 8'hA5,
  parameter int unsigned FRAME_LEN  = 16,
  parameter int unsigned CONFIRM    = 2,
  parameter int unsigned MISS_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        force_hunt,
  output logic [14:0] z,
  output logic [2:0]  k,
  output logic        out_valid,
  output logic        sync_det,
  output logic        locked,
  output logic [1:0]  state_o
);

  localparam int unsigned FCNT_W  = $clog2(FRAME_LEN);
  localparam int unsigned MATCH_W = $clog2(CONFIRM + 1);
  localparam int unsigned MISS_W  = $clog2(MISS_LIMIT + 1);

  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_HUNT   = 2'd1;
  localparam logic [1:0] ST_VERIFY = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  localparam logic [FCNT_W-1:0]  FCNT_LAST = FCNT_W'(FRAME_LEN - 1);
  localparam logic [MATCH_W-1:0] MATCH_TGT = MATCH_W'(CONFIRM);
  localparam logic [MISS_W-1:0]  MISS_TGT  = MISS_W'(MISS_LIMIT);

  logic [7:0]         prev_q, prev_d;
  logic [7:0]         curr_q, curr_d;
  logic               win_fresh_q, win_fresh_d;
  logic [2:0]         k_q, k_d;
  logic [1:0]         state_q, state_d;
  logic               fill_q, fill_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic               sync_det_q, sync_det_d;

  logic [14:0]        win;
  logic [7:0]         aligned;
  logic               a_match;
  logic               sync_pos;
  logic               hunt_hit;
  logic [2:0]         hunt_k;
  logic [FCNT_W-1:0]  fcnt_inc;
  logic [MATCH_W-1:0] match_inc;
  logic [MISS_W-1:0]  miss_inc;

  assign win       = {curr_q[6:0], prev_q};
  assign aligned   = 8'(win >> k_q);
  assign a_match   = (aligned == SYNC);
  assign sync_pos  = (fcnt_q == '0);
  assign fcnt_inc  = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + FCNT_W'(1);
  assign match_inc = match_q + MATCH_W'(1);
  assign miss_inc  = miss_q + MISS_W'(1);

  // Scan high to low so the lowest matching offset is the one kept.
  always_comb begin
    hunt_hit = 1'b0;
    hunt_k   = 3'd0;
    for (int j = 7; j >= 0; j--) begin
      if (win[j +: 8] == SYNC) begin
        hunt_hit = 1'b1;
        hunt_k   = 3'(j);
      end
    end
  end

  always_comb begin
    prev_d      = prev_q;
    curr_d      = curr_q;
    win_fresh_d = in_valid;
    state_d     = state_q;
    k_d         = k_q;
    fill_d      = fill_q;
    fcnt_d      = fcnt_q;
    match_d     = match_q;
    miss_d      = miss_q;
    sync_det_d  = 1'b0;

    if (in_valid) begin
      prev_d = curr_q;
      curr_d = in_data;
    end

    case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          if (fill_q) begin
            state_d = ST_HUNT;
            fill_d  = 1'b0;
          end else begin
            fill_d  = 1'b1;
          end
        end
      end

      ST_HUNT: begin
        if (win_fresh_q && hunt_hit) begin
          k_d        = hunt_k;
          fcnt_d     = FCNT_W'(1);
          match_d    = MATCH_W'(1);
          sync_det_d = 1'b1;
          if (CONFIRM == 1) begin
            state_d = ST_LOCKED;
            miss_d  = '0;
          end else begin
            state_d = ST_VERIFY;
          end
        end
      end

      ST_VERIFY: begin
        if (win_fresh_q) begin
          fcnt_d = fcnt_inc;
          if (sync_pos) begin
            if (a_match) begin
              sync_det_d = 1'b1;
              match_d    = match_inc;
              if (match_inc == MATCH_TGT) begin
                state_d = ST_LOCKED;
                miss_d  = '0;
              end
            end else begin
              // k is kept; the next hunt hit overwrites it.
              state_d = ST_HUNT;
              fcnt_d  = '0;
              match_d = '0;
            end
          end
        end
      end

      default: begin
        if (win_fresh_q) begin
          fcnt_d = fcnt_inc;
          if (sync_pos) begin
            if (a_match) begin
              sync_det_d = 1'b1;
              miss_d     = '0;
            end else if (miss_inc == MISS_TGT) begin
              state_d = ST_HUNT;
              fcnt_d  = '0;
              match_d = '0;
              miss_d  = '0;
            end else begin
              miss_d  = miss_inc;
            end
          end
        end
      end
    endcase

    // Re-hunt request wins over the evaluation result but not the sync pulse.
    if (force_hunt && (state_q != ST_FILL)) begin
      state_d = ST_HUNT;
      k_d     = k_q;
      fcnt_d  = '0;
      match_d = '0;
      miss_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q      <= '0;
      curr_q      <= '0;
      win_fresh_q <= 1'b0;
      k_q         <= '0;
      state_q     <= ST_FILL;
      fill_q      <= 1'b0;
      fcnt_q      <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      sync_det_q  <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      curr_q      <= curr_d;
      win_fresh_q <= win_fresh_d;
      k_q         <= k_d;
      state_q     <= state_d;
      fill_q      <= fill_d;
      fcnt_q      <= fcnt_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      sync_det_q  <= sync_det_d;
    end
  end

  assign z         = win;
  assign k         = k_q;
  assign sync_det  = sync_det_q;
  assign locked    = (state_q == ST_LOCKED);
  assign state_o   = state_q;
  assign out_valid = (state_q == ST_LOCKED) && win_fresh_q && (fcnt_q != '0);

endmodule

// File: tb/tb_frame_bit_aligner.sv
// Directed bench for frame_bit_aligner: builds a bit-delayed framed stream and
// checks hunt, verify, lock, loss, force_hunt, idle gaps and reset behaviour.
module tb_frame_bit_aligner;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        force_hunt;
  logic [14:0] z;
  logic [2:0]  k;
  logic        out_valid;
  logic        sync_det;
  logic        locked;
  logic [1:0]  state_o;

  int n_cmp = 0;
  int n_bad = 0;
  int sd_count = 0;
  int gap = 0;

  bit         bitq[$];
  bit         pend_vld = 1'b0;
  logic [7:0] pend_val = 8'h00;
  bit         pend_ov = 1'b0;

  frame_bit_aligner dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .force_hunt (force_hunt),
    .z          (z),
    .k          (k),
    .out_valid  (out_valid),
    .sync_det   (sync_det),
    .locked     (locked),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sync_det) sd_count++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pl(input int f, input int i);
    return {4'h0, 4'(f + i)};
  endfunction

  task automatic tx_raw(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
  endtask

  // Send one frame byte through the bit-delay line; the window then shows the
  // byte sent before it, whose out_valid and shifter output are checked here.
  task automatic tx_byte(input logic [7:0] b, input bit ov);
    logic [7:0]  raw;
    logic [14:0] sh;
    for (int i = 0; i < 8; i++) bitq.push_back(b[i]);
    for (int i = 0; i < 8; i++) raw[i] = bitq.pop_front();
    tx_raw(raw);
    if (pend_vld) begin
      check_eq("out_valid", 32'(out_valid), 32'(pend_ov));
      if (pend_ov) begin
        sh = z >> k;
        check_eq("payload", 32'(sh[7:0]), 32'(pend_val));
      end
    end
    pend_vld = 1'b1;
    pend_val = b;
    pend_ov  = ov;
    if (gap > 0) begin
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("gap_ov", 32'(out_valid), 32'(0));
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic tx_frame(input logic [7:0] sync_b, input bit lock, input int f);
    tx_byte(sync_b, 1'b0);
    for (int i = 1; i < 16; i++) tx_byte(pl(f, i), lock);
  endtask

  task automatic add_delay(input int n);
    for (int i = 0; i < n; i++) bitq.push_back(1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    force_hunt = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_z", 32'(z), 32'(0));
    check_eq("rst_k", 32'(k), 32'(0));
    check_eq("rst_state", 32'(state_o), 32'(0));
    check_eq("rst_ov", 32'(out_valid), 32'(0));
    check_eq("rst_locked", 32'(locked), 32'(0));
    check_eq("rst_sd", 32'(sync_det), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // Frame 0, stream delayed by 3 bits: raw 0x00, 0x28, 0x0D ...
    add_delay(3);
    tx_byte(8'h00, 1'b0);
    check_eq("fill_1byte", 32'(state_o), 32'(0));
    tx_byte(8'hA5, 1'b0);
    check_eq("fill_to_hunt", 32'(state_o), 32'(1));
    tx_byte(pl(0, 1), 1'b0);
    check_eq("sync_window", 32'(z), 32'(15'h0D28));
    check_eq("hunt_wait", 32'(state_o), 32'(1));
    tx_byte(pl(0, 2), 1'b0);
    check_eq("hit_sd", 32'(sync_det), 32'(1));
    check_eq("hit_k", 32'(k), 32'(3));
    check_eq("hit_verify", 32'(state_o), 32'(2));
    for (int i = 3; i < 16; i++) tx_byte(pl(0, i), 1'b0);
    #1;
    check_eq("sd_f0", 32'(sd_count), 32'(1));
    check_eq("f0_unlocked", 32'(locked), 32'(0));

    // Second match locks; payload flagged and aligned
    tx_frame(8'hA5, 1'b1, 1);
    #1;
    check_eq("f1_locked", 32'(locked), 32'(1));
    check_eq("sd_f1", 32'(sd_count), 32'(2));
    tx_frame(8'hA5, 1'b1, 2);
    #1;
    check_eq("sd_f2", 32'(sd_count), 32'(3));
    check_eq("f2_k", 32'(k), 32'(3));

    // Two corrupted syncs tolerated, third drops to HUNT
    tx_frame(8'h00, 1'b1, 3);
    tx_frame(8'h00, 1'b1, 4);
    check_eq("miss2_locked", 32'(state_o), 32'(3));
    tx_frame(8'h00, 1'b0, 5);
    check_eq("miss3_hunt", 32'(state_o), 32'(1));
    check_eq("miss3_unlocked", 32'(locked), 32'(0));
    #1;
    check_eq("sd_miss", 32'(sd_count), 32'(3));

    // New 6-bit offset: hunt, verify, relock
    add_delay(3);
    tx_frame(8'hA5, 1'b0, 6);
    #1;
    check_eq("k6", 32'(k), 32'(6));
    check_eq("k6_verify", 32'(state_o), 32'(2));
    check_eq("sd_f6", 32'(sd_count), 32'(4));
    tx_frame(8'hA5, 1'b1, 7);
    #1;
    check_eq("relock", 32'(locked), 32'(1));
    check_eq("sd_f7", 32'(sd_count), 32'(5));

    // force_hunt coincident with a good sync window while locked
    tx_byte(8'hA5, 1'b0);
    tx_byte(pl(8, 1), 1'b0);
    force_hunt = 1'b1;
    tx_byte(pl(8, 2), 1'b0);
    force_hunt = 1'b0;
    check_eq("force_state", 32'(state_o), 32'(1));
    check_eq("force_sd", 32'(sync_det), 32'(1));
    check_eq("force_ov", 32'(out_valid), 32'(0));
    check_eq("force_k", 32'(k), 32'(6));
    for (int i = 3; i < 16; i++) tx_byte(pl(8, i), 1'b0);
    #1;
    check_eq("sd_f8", 32'(sd_count), 32'(6));

    // Idle gaps of 5 cycles between bytes freeze the frame counter
    gap = 5;
    tx_frame(8'hA5, 1'b0, 9);
    check_eq("gap_verify", 32'(state_o), 32'(2));
    tx_frame(8'hA5, 1'b1, 10);
    check_eq("gap_locked", 32'(locked), 32'(1));
    tx_frame(8'hA5, 1'b1, 11);
    check_eq("gap_state", 32'(state_o), 32'(3));
    #1;
    check_eq("sd_gap", 32'(sd_count), 32'(9));
    gap = 0;

    // Asynchronous reset while locked
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mrst_z", 32'(z), 32'(0));
    check_eq("mrst_k", 32'(k), 32'(0));
    check_eq("mrst_state", 32'(state_o), 32'(0));
    check_eq("mrst_ov", 32'(out_valid), 32'(0));
    check_eq("mrst_locked", 32'(locked), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Window 0x294A holds A5 at k=1 and k=6; lowest wins
    pend_vld = 1'b0;
    tx_raw(8'h4A);
    check_eq("dual_fill", 32'(state_o), 32'(0));
    tx_raw(8'h29);
    check_eq("dual_hunt", 32'(state_o), 32'(1));
    check_eq("dual_z", 32'(z), 32'(15'h294A));
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("dual_k", 32'(k), 32'(1));
    check_eq("dual_state", 32'(state_o), 32'(2));
    check_eq("dual_sd", 32'(sync_det), 32'(1));
    #1;
    check_eq("sd_dual", 32'(sd_count), 32'(10));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
